prog_mem_loadable: RTL and testbench
====================================

Name: prog_mem_loadable

Overview:
Parametrised program memory for the 8-bit CPU with a byte-stream boot loader. After reset it sweeps every location to a fill opcode (NOP). It then accepts a framed program image over a valid/ready byte port and holds the CPU while loading. It serves instruction fetch with two combinational read ports: the current byte and the next byte, so two-byte instructions are fetched in one access.

Parameters:
DATA_W, 8, memory word / loader byte width
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
FILL_WORD, 8'b0111_0000, value written to every location by the clear sweep (NOP)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low
address_bus  input  ADDR_W  CPU fetch address
data_bus  output  DATA_W  mem[address_bus], combinational
data_bus_next  output  DATA_W  mem[(address_bus+1) mod DEPTH], combinational
cpu_hold  output  1  high while the CPU must stall (clear or load in progress)
ld_start  input  1  request a new image load; sampled only in RUN
ld_valid  input  1  loader byte valid
ld_data  input  DATA_W  loader byte
ld_ready  output  1  block accepts a byte; transfer occurs on an edge with ld_valid && ld_ready
load_done  output  1  one-cycle pulse: image accepted, checksum good
load_error  output  1  sticky: last image checksum bad; cleared by next accepted ld_start or reset

Behaviour:
- reset is synchronous, active-low. Any edge with reset==0 sets state=CLEAR, ptr=0, sum=0, cnt=0, cpu_hold=1, ld_ready=0, load_done=0, load_error=0. No memory writes occur while reset==0. Reset mid-load aborts the load; the sweep then wipes the partial image.
- cpu_hold and ld_ready decode from registered state (no combinational path from inputs). cpu_hold=1 in CLEAR, HDR, DATA, CSUM; 0 in RUN. ld_ready=1 in HDR, DATA, CSUM; 0 otherwise.
- Reads are asynchronous in all states. A location written on edge N reads back new data after edge N. data_bus_next wraps: address DEPTH-1 returns mem[0].
- CLEAR: each edge writes FILL_WORD to mem[ptr] and increments ptr. On the edge writing ptr=DEPTH-1 the state goes to RUN. Total: exactly DEPTH edges after reset release. ld_start is ignored here.
- RUN: ld_start==1 -> HDR, with ptr=0, sum=0, load_error=0 on that edge. Otherwise stay.
- HDR: on a transfer, cnt=ld_data (image length L, 0..2**DATA_W-1) and sum=ld_data. Next state is DATA, or CSUM if L==0.
- DATA: each transfer writes ld_data to mem[ptr], ptr=(ptr+1) mod DEPTH, sum=sum+ld_data mod 2**DATA_W, cnt=cnt-1. The transfer with cnt==1 moves to CSUM. If L>DEPTH, addresses wrap and later bytes overwrite earlier ones.
- CSUM: on a transfer, good = ((sum+ld_data) mod 2**DATA_W == 0), i.e. the checksum is the two's complement of length plus all data bytes. State -> RUN. If good, load_done=1 for exactly the next cycle. Otherwise load_error=1 (held).
- A bad checksum does not roll back memory; the written bytes remain.
- ld_valid with ld_ready==0 is ignored and no byte is consumed. ld_start outside RUN is ignored. ld_ready does not depend on ld_valid.
- Locations beyond L keep their previous contents, which are not re-cleared.

Test Plan:
- Reset low 3 edges, release -> cpu_hold=1 for exactly 256 edges, then 0. All mem reads 8'h70; data_bus_next at address 255 returns mem[0]=8'h70.
- In RUN, pulse ld_start, send 3,8'h80,8'h01,8'h00, then checksum 8'h7C (3+0x80+1+0 = 0x84, 0x84+0x7C = 0x100) -> mem[0..2]=80,01,00, mem[3]=70, load_done one pulse, load_error=0, cpu_hold=0.
- Same frame with checksum 8'h00 -> load_error=1 and held. Next ld_start clears it; a good reload pulses load_done.
- Toggle ld_valid 1/0 every cycle during DATA, with ld_data changing while invalid -> only valid bytes are written, in order, with no duplicates.
- Length 0, checksum 8'h00 -> load_done pulse with no memory change. Assert ld_start during CLEAR -> no effect.
- Assert reset low after 2 data bytes -> CLEAR restarts, full 256-edge sweep, mem[0..1]=8'h70, load_done never pulses.

Source files
------------

// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable
//   Program memory for the 8-bit CPU. It has a byte-stream boot loader.
//   After reset, a clear sweep writes FILL_WORD (NOP) to every location.
//   The block then waits in RUN. An ld_start request opens a framed image load:
//     [length L] [L data bytes] [checksum]
//   The checksum is good when (L + sum(data) + checksum) mod 2**DATA_W == 0.
//   Fetch uses two asynchronous read ports: the current word and the next word.
//   The next-word port wraps from DEPTH-1 to 0.
// Ports
//   clk, reset          clock; synchronous active-low reset
//   address_bus         CPU fetch address
//   data_bus            mem[address_bus]
//   data_bus_next       mem[address_bus+1], wraps
//   cpu_hold            stall the CPU during clear or load
//   ld_start            request an image load (only seen in RUN)
//   ld_valid/ld_data    loader byte stream
//   ld_ready            loader byte accept (registered decode only)
//   load_done           one-cycle pulse when an image is accepted with a good checksum
//   load_error          sticky flag for a bad checksum on the last image
module prog_mem_loadable #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'b0111_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] data_bus_next,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              load_done,
  output logic              load_error
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    S_CLEAR, S_RUN, S_HDR, S_DATA, S_CSUM
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [DATA_W-1:0] sum, sum_n;
  logic [DATA_W-1:0] cnt, cnt_n;
  logic              done_n, err_n;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              xfer;
  logic [ADDR_W-1:0] addr_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read ports are asynchronous and are never gated by state.
  assign addr_nx       = ADDR_W'(address_bus + 1'b1);
  assign data_bus      = mem[address_bus];
  assign data_bus_next = mem[addr_nx];

  // Decode only from registered state, so there is no input-to-output path.
  assign cpu_hold = (state != S_RUN);
  assign ld_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign xfer     = ld_valid && ld_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_CLEAR;
      ptr        <= '0;
      sum        <= '0;
      cnt        <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      sum        <= sum_n;
      cnt        <= cnt_n;
      load_done  <= done_n;
      load_error <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sum_n   = sum;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = load_error;
    we      = 1'b0;
    wdata   = ld_data;
    case (state)
      S_CLEAR: begin
        we    = 1'b1;
        wdata = FILL_WORD;
        ptr_n = ptr + 1'b1;
        if (&ptr) state_n = S_RUN;
      end
      S_RUN: begin
        if (ld_start) begin
          state_n = S_HDR;
          ptr_n   = '0;
          sum_n   = '0;
          err_n   = 1'b0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          cnt_n   = ld_data;
          sum_n   = ld_data;
          state_n = (ld_data == '0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          we    = 1'b1;
          ptr_n = ptr + 1'b1;
          sum_n = sum + ld_data;
          cnt_n = cnt - 1'b1;
          if (cnt == DATA_W'(1)) state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_n = S_RUN;
          if (DATA_W'(sum + ld_data) == '0) done_n = 1'b1;
          else                              err_n  = 1'b1;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  // The memory has no reset. Writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (reset && we) mem[ptr] <= wdata;
  end

endmodule

// File: tb/tb_prog_mem_loadable.sv
module tb_prog_mem_loadable;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address_bus;
  logic [7:0] data_bus, data_bus_next;
  logic       cpu_hold, ld_start, ld_valid, ld_ready, load_done, load_error;
  logic [7:0] ld_data;

  prog_mem_loadable dut (
    .clk(clk), .reset(reset), .address_bus(address_bus),
    .data_bus(data_bus), .data_bus_next(data_bus_next),
    .cpu_hold(cpu_hold), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  // reference model: memory image, expected flags, expected done pulses
  logic [7:0] model [256];
  logic [7:0] img [$];
  logic       exp_err;
  int         exp_done;
  int         done_seen;
  int         n_cmp, n_bad;

  always @(negedge clk) if (load_done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_mem();
    for (int a = 0; a < 256; a++) begin
      address_bus = 8'(a);
      #1;
      chk($sformatf("data_bus[%0d]", a), data_bus, model[a]);
      chk($sformatf("data_bus_next[%0d]", a), data_bus_next, model[(a+1)%256]);
    end
  endtask

  // Hold reset low for some edges, release it, then time the clear sweep.
  // ld_start is pulsed early in the sweep and must have no effect.
  task automatic do_reset(input int edges);
    int hold_cnt;
    reset = 1'b0; ld_valid = 1'b0; ld_start = 1'b0;
    repeat (edges) step();
    chk("rst_hold", cpu_hold, 1);
    chk("rst_ready", ld_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    reset = 1'b1;
    hold_cnt = 0;
    @(negedge clk);
    while (cpu_hold && hold_cnt < 1000) begin
      hold_cnt++;
      ld_start = (hold_cnt < 4);
      @(negedge clk);
    end
    ld_start = 1'b0;
    chk("clear_edges", hold_cnt, 256);
    for (int i = 0; i < 256; i++) model[i] = 8'h70;
    exp_err = 1'b0;
  endtask

  task automatic wait_run();
    int t = 0;
    @(negedge clk);
    while (cpu_hold && t < 1000) begin @(negedge clk); t++; end
    chk("wait_run", cpu_hold, 0);
    step();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
    int t = 0;
    repeat ($urandom_range(gmax, gmin)) begin
      ld_valid = 1'b0; ld_data = 8'($urandom); step();
    end
    ld_valid = 1'b1; ld_data = b;
    @(negedge clk);
    while (!ld_ready && t < 50) begin step(); @(negedge clk); t++; end
    chk("ld_ready", ld_ready, 1);
    step();
    ld_valid = 1'b0; ld_data = 8'($urandom);
  endtask

  function automatic logic [7:0] good_csum();
    logic [7:0] s = 8'(img.size());
    foreach (img[i]) s = s + img[i];
    return 8'(-s);
  endfunction

  task automatic pulse_start();
    wait_run();
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("start_hold", cpu_hold, 1);
    chk("start_ready", ld_ready, 1);
    chk("start_err_clr", load_error, 0);
    exp_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] csum, input int gmin, input int gmax);
    logic [7:0] s;
    logic       good;
    pulse_start();
    s = 8'(img.size());
    send_byte(s, gmin, gmax);
    foreach (img[i]) begin
      send_byte(img[i], gmin, gmax);
      model[i % 256] = img[i];
      s = s + img[i];
    end
    send_byte(csum, gmin, gmax);
    good = (8'(s + csum) == 8'h00);
    if (good) exp_done++; else exp_err = 1'b1;
    chk("done_pulse", load_done, good);
    step();
    chk("done_low", load_done, 0);
    chk("load_error", load_error, exp_err);
    chk("hold_run", cpu_hold, 0);
    chk("done_count", done_seen, exp_done);
    check_mem();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; done_seen = 0; exp_done = 0; exp_err = 1'b0;
    reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; address_bus = 8'h00;

    do_reset(3);
    check_mem();

    // directed frame with a good checksum
    img = '{8'h80, 8'h01, 8'h00};
    send_frame(8'h7C, 0, 0);
    // the same frame with a bad checksum makes the error sticky
    send_frame(8'h00, 0, 0);
    repeat (3) step();
    chk("err_sticky", load_error, 1);
    // reload with ld_valid toggling every cycle
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(good_csum(), 1, 1);
    // zero-length image
    img = {};
    send_frame(8'h00, 0, 0);

    // in RUN, ld_valid must not consume anything
    repeat (5) begin
      ld_valid = 1'b1; ld_data = 8'($urandom);
      @(negedge clk); chk("run_not_ready", ld_ready, 0);
      step();
    end
    ld_valid = 1'b0;
    check_mem();

    // random frames
    for (int f = 0; f < 12; f++) begin
      int len = $urandom_range(40, 0);
      img = {};
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      if ($urandom_range(9, 0) < 7) send_frame(good_csum(), 0, 2);
      else send_frame(8'(good_csum() + 8'($urandom_range(255, 1))), 0, 2);
    end

    // reset in the middle of a load wipes the partial image
    pulse_start();
    send_byte(8'h05, 0, 0);
    send_byte(8'hAA, 0, 0);
    send_byte(8'hBB, 0, 0);
    do_reset(1);
    repeat (3) step();
    chk("abort_no_done", done_seen, exp_done);
    chk("abort_err", load_error, 0);
    check_mem();

    img = '{8'hDE, 8'hAD};
    send_frame(good_csum(), 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
